// File: rtl/cosine_job_sequencer.sv
// Job sequencer for the cosine-similarity engine: queues operand pairs,
// launches one engine job at a time, and returns tagged results or timeout aborts.
module cosine_job_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a_vec,
  input  logic [31:0] in_b_vec,
  output logic        eng_start,
  output logic [31:0] eng_a_vec,
  output logic [31:0] eng_b_vec,
  input  logic        eng_done,
  input  logic [15:0] eng_cos_sim,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_cos_sim,
  output logic [1:0]  out_tag,
  output logic        out_err,
  output logic        busy,
  output logic [4:0]  pending
);

  localparam int unsigned VEC_W  = 32;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned TAG_W  = 2;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LCNT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [TAG_W-1:0] tag;
  } job_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t state_q, state_d;

  job_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] job_tag, job_tag_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic             push, pop;
  logic [CNT_W-1:0] pending_d;
  logic             in_ready_d, eng_start_d, busy_d;
  logic [VEC_W-1:0] eng_a_d, eng_b_d;
  logic             out_valid_d, out_err_d;
  logic [RES_W-1:0] out_cos_d;
  logic [TAG_W-1:0] out_tag_d;
  job_t             head;

  assign push = in_valid && in_ready;
  assign head = mem[rd_ptr];

  // Queue storage; occupancy and pointers live in the reset domain below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_a_vec, b: in_b_vec, tag: tag_cnt};
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    lcnt_d      = lcnt_q;
    wcnt_d      = wcnt_q;
    job_tag_d   = job_tag;
    eng_a_d     = eng_a_vec;
    eng_b_d     = eng_b_vec;
    out_valid_d = out_valid;
    out_cos_d   = out_cos_sim;
    out_tag_d   = out_tag;
    out_err_d   = out_err;

    unique case (state_q)
      IDLE: begin
        if ((pending != '0) && !out_valid && !eng_done) begin
          state_d   = LAUNCH;
          pop       = 1'b1;
          lcnt_d    = '0;
          eng_a_d   = head.a;
          eng_b_d   = head.b;
          job_tag_d = head.tag;
        end
      end
      LAUNCH: begin
        if (lcnt_q == LCNT_W'(START_CYCLES - 1)) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
        end
      end
      WAIT: begin
        // A completion on the timeout cycle is still a real result.
        if (eng_done) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_cos_d   = eng_cos_sim;
          out_tag_d   = job_tag;
          out_err_d   = 1'b0;
        end else if (wcnt_q == WCNT_W'(TIMEOUT)) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_cos_d   = 16'hFFFF;
          out_tag_d   = job_tag;
          out_err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case ({push, pop})
      2'b10:   pending_d = pending + CNT_W'(1);
      2'b01:   pending_d = pending - CNT_W'(1);
      default: pending_d = pending;
    endcase

    in_ready_d  = pending_d < CNT_W'(DEPTH);
    eng_start_d = (state_d == LAUNCH);
    busy_d      = (state_d != IDLE);
  end

  // State, queue bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_cnt     <= '0;
      job_tag     <= '0;
      lcnt_q      <= '0;
      wcnt_q      <= '0;
      pending     <= '0;
      in_ready    <= 1'b0;
      eng_start   <= 1'b0;
      eng_a_vec   <= '0;
      eng_b_vec   <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_cos_sim <= '0;
      out_tag     <= '0;
      out_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      job_tag     <= job_tag_d;
      lcnt_q      <= lcnt_d;
      wcnt_q      <= wcnt_d;
      pending     <= pending_d;
      in_ready    <= in_ready_d;
      eng_start   <= eng_start_d;
      eng_a_vec   <= eng_a_d;
      eng_b_vec   <= eng_b_d;
      busy        <= busy_d;
      out_valid   <= out_valid_d;
      out_cos_sim <= out_cos_d;
      out_tag     <= out_tag_d;
      out_err     <= out_err_d;
    end
  end

endmodule

// File: tb/tb_cosine_job_sequencer.sv
// Directed bench for cosine_job_sequencer: launch timing, queue fill, hold,
// timeout abort, done-on-timeout boundary and mid-job reset.
module tb_cosine_job_sequencer;

  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 255;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a_vec;
  logic [31:0] in_b_vec;
  logic        eng_start;
  logic [31:0] eng_a_vec;
  logic [31:0] eng_b_vec;
  logic        eng_done;
  logic [15:0] eng_cos_sim;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cos_sim;
  logic [1:0]  out_tag;
  logic        out_err;
  logic        busy;
  logic [4:0]  pending;

  int checks = 0;
  int errors = 0;

  cosine_job_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_vec(in_a_vec), .in_b_vec(in_b_vec),
    .eng_start(eng_start), .eng_a_vec(eng_a_vec), .eng_b_vec(eng_b_vec),
    .eng_done(eng_done), .eng_cos_sim(eng_cos_sim),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cos_sim(out_cos_sim), .out_tag(out_tag), .out_err(out_err),
    .busy(busy), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push_job(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_a_vec = a;
    in_b_vec = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Returns on the first WAIT cycle (wait counter at 0).
  task automatic launch_and_wait(input logic [31:0] a, input logic [31:0] b);
    int n;
    int starts;
    n = 0;
    while (eng_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("launch_seen", 32'(n < 100), 32'd1);
    starts = 0;
    while (eng_start === 1'b1 && starts < 10) begin
      check("launch_a_vec", eng_a_vec, a);
      check("launch_b_vec", eng_b_vec, b);
      starts++;
      tick();
    end
    check("start_cycles", 32'(starts), 32'(START_CYCLES));
    check("wait_busy", busy, 1'b1);
  endtask

  // eng_done is sampled on the edge where the wait counter equals n.
  task automatic finish_done(input int n, input logic [15:0] res);
    repeat (n) tick();
    check("no_early_result", out_valid, 1'b0);
    eng_done    = 1'b1;
    eng_cos_sim = res;
    tick();
    eng_done    = 1'b0;
    eng_cos_sim = 16'h0000;
  endtask

  task automatic check_result(input logic [15:0] cos, input logic [1:0] tag, input logic err,
                              input logic [31:0] a, input logic [31:0] b);
    check("res_valid", out_valid, 1'b1);
    check("res_cos", out_cos_sim, cos);
    check("res_tag", out_tag, tag);
    check("res_err", out_err, err);
    check("res_a_stable", eng_a_vec, a);
    check("res_b_stable", eng_b_vec, b);
    check("res_start_low", eng_start, 1'b0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid_clear", out_valid, 1'b0);
    check("hs_idle", busy, 1'b0);
  endtask

  logic [31:0] fa [5];
  logic [31:0] fb [5];
  logic [15:0] fr [5];
  logic [31:0] ha [3];
  logic [31:0] hb [3];

  initial begin
    fa = '{32'h0A0B0C0D, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF01};
    fb = '{32'h01020304, 32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F001};
    fr = '{16'h1000, 16'h2001, 16'h3002, 16'h4003, 16'h5004};
    ha = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    hb = '{32'h1A2A3A4A, 32'h1B2B3B4B, 32'h1C2C3C4C};

    reset = 1'b0; in_valid = 1'b0; in_a_vec = '0; in_b_vec = '0;
    eng_done = 1'b0; eng_cos_sim = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_pending", pending, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_cos", out_cos_sim, 16'h0000);
    check("rst_eng_a", eng_a_vec, 32'h0);

    reset = 1'b1;
    check("rel_in_ready_low", in_ready, 1'b0);
    tick();
    check("rel_in_ready_high", in_ready, 1'b1);

    // Single job through the engine.
    push_job(32'h04030201, 32'h08070605);
    check("single_pending", pending, 5'd1);
    launch_and_wait(32'h04030201, 32'h08070605);
    finish_done(20, 16'h7E5A);
    check_result(16'h7E5A, 2'd0, 1'b0, 32'h04030201, 32'h08070605);
    handshake();

    // Reset in the middle of WAIT discards the job.
    push_job(32'hCAFEBABE, 32'hDEADBEEF);
    launch_and_wait(32'hCAFEBABE, 32'hDEADBEEF);
    repeat (5) tick();
    #3 reset = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_pending", pending, 5'd0);
    check("midrst_eng_a", eng_a_vec, 32'h0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_ready_back", in_ready, 1'b1);
    check("midrst_no_output", out_valid, 1'b0);

    // Fill the queue while the engine holds eng_done.
    eng_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_job(fa[i], fb[i]);
      check("fill_pending", pending, 5'(i + 1));
    end
    check("fill_full_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_a_vec = fa[4]; in_b_vec = fb[4];
    tick();
    tick();
    check("fill_held_pending", pending, 5'd4);
    check("fill_held_ready", in_ready, 1'b0);
    check("fill_stall_idle", busy, 1'b0);
    in_valid = 1'b0;
    eng_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      launch_and_wait(fa[i], fb[i]);
      finish_done(3 + i, fr[i]);
      check_result(fr[i], 2'(i), 1'b0, fa[i], fb[i]);
      handshake();
    end
    push_job(fa[4], fb[4]);
    launch_and_wait(fa[4], fb[4]);
    finish_done(2, fr[4]);
    check_result(fr[4], 2'd0, 1'b0, fa[4], fb[4]);
    handshake();

    // Three queued jobs: held result, timeout abort, done on the timeout cycle.
    eng_done = 1'b1;
    for (int i = 0; i < 3; i++) push_job(ha[i], hb[i]);
    check("trio_pending", pending, 5'd3);
    eng_done = 1'b0;

    launch_and_wait(ha[0], hb[0]);
    finish_done(4, 16'h1234);
    check_result(16'h1234, 2'd1, 1'b0, ha[0], hb[0]);
    repeat (10) begin
      tick();
      check("hold_valid", out_valid, 1'b1);
      check("hold_cos", out_cos_sim, 16'h1234);
      check("hold_tag", out_tag, 2'd1);
      check("hold_err", out_err, 1'b0);
      check("hold_no_start", eng_start, 1'b0);
      check("hold_pending", pending, 5'd2);
    end
    handshake();

    launch_and_wait(ha[1], hb[1]);
    repeat (TIMEOUT) tick();
    check("to_not_yet", out_valid, 1'b0);
    tick();
    check_result(16'hFFFF, 2'd2, 1'b1, ha[1], hb[1]);
    repeat (3) begin
      tick();
      check("to_no_start", eng_start, 1'b0);
      check("to_pending", pending, 5'd1);
      check("to_err_hold", out_err, 1'b1);
    end
    handshake();

    launch_and_wait(ha[2], hb[2]);
    finish_done(TIMEOUT, 16'h0ACE);
    check_result(16'h0ACE, 2'd3, 1'b0, ha[2], hb[2]);
    handshake();
    check("end_pending", pending, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cosine_job_sequencer.md
COSINE_JOB_SEQUENCER -- requirements
Module: cosine_job_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: input job FIFO depth, power of two, 2..16.
REQ-002 Parameter START_CYCLES, default 2: cycles eng_start is held high per launch.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles before a job is aborted.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  job offered.
REQ-007 in_ready  out  1  job FIFO can accept.
REQ-008 in_a_vec  in  32  vector A, four unsigned 8-bit elements.
REQ-009 in_b_vec  in  32  vector B, four unsigned 8-bit elements.
REQ-010 eng_start  out  1  start to the cosine-similarity control store.
REQ-011 eng_a_vec  out  32  A_vec to the engine.
REQ-012 eng_b_vec  out  32  B_vec to the engine.
REQ-013 eng_done  in  1  engine completion.
REQ-014 eng_cos_sim  in  16  engine cosine_similarity result.
REQ-015 out_valid  out  1  result register holds a result.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 out_cos_sim  out  16  result value.
REQ-018 out_tag  out  2  job tag of the result.
REQ-019 out_err  out  1  result is a timeout abort.
REQ-020 busy  out  1  FSM not in IDLE.
REQ-021 pending  out  5  FIFO occupancy, 0..DEPTH.

Function
REQ-022 Push happens when in_valid && in_ready; in_ready = (pending < DEPTH); when full, in_ready stays 0 even if a pop occurs in the same cycle.
REQ-023 Each pushed job gets tag = 2-bit counter, starting at 0 and incrementing per push, wrapping 3->0.
REQ-024 Simultaneous push and pop leaves pending unchanged; order is strictly FIFO.
REQ-025 FSM states: IDLE, LAUNCH, WAIT, HOLD.
REQ-026 IDLE->LAUNCH when pending>0, out_valid==0 and eng_done==0; the head job is popped into the engine operand register (eng_a_vec, eng_b_vec, tag) on that transition.
REQ-027 LAUNCH: eng_start=1 for exactly START_CYCLES cycles, then ->WAIT; eng_start is 0 in every other state.
REQ-028 eng_a_vec/eng_b_vec remain stable from LAUNCH entry until the FSM re-enters IDLE.
REQ-029 WAIT: a cycle counter starts at 0 on entry and increments each cycle; eng_done sampled 1 captures eng_cos_sim into out_cos_sim, sets out_tag=job tag, out_err=0, out_valid=1, ->HOLD.
REQ-030 WAIT: when the counter reaches TIMEOUT with eng_done==0, out_cos_sim=16'hFFFF, out_err=1, out_valid=1, ->HOLD.
REQ-031 eng_done and timeout in the same cycle: eng_done wins (out_err=0).
REQ-032 HOLD->IDLE on the cycle out_valid && out_ready; out_valid clears that cycle.
REQ-033 out_cos_sim, out_tag and out_err remain stable while out_valid==1 and out_ready==0.
REQ-034 Minimum job turnaround is IDLE(1)+LAUNCH(START_CYCLES)+WAIT(>=1)+HOLD(>=1) cycles; there is no overlap of engine jobs.
REQ-035 busy = (state != IDLE); pending reflects the count after the current edge.

Reset
REQ-036 reset low asynchronously forces IDLE, empties the FIFO, sets tag counter to 0 and clears the WAIT counter.
REQ-037 During reset: eng_start=0, out_valid=0, out_err=0, out_cos_sim=0, out_tag=0, eng_a_vec=0, eng_b_vec=0, busy=0, pending=0, in_ready=0.
REQ-038 in_ready rises on the first clock edge after reset deasserts; a job in flight at reset is discarded with no output.

Verification
REQ-039 Single job A=32'h04030201, B=32'h08070605, engine model returns 16'h7E5A after 20 cycles -> eng_start high exactly 2 cycles, eng vectors stable, out_valid with out_cos_sim=16'h7E5A, out_tag=0, out_err=0.
REQ-040 Push 5 jobs back-to-back with engine stalled -> in_ready drops after 4 (pending=4), 5th held off; results later emerge with tags 0,1,2,3,0 in order.
REQ-041 Engine never asserts eng_done -> after TIMEOUT cycles in WAIT, out_cos_sim=16'hFFFF, out_err=1; next job launches only after out_ready.
REQ-042 out_ready held 0 for 10 cycles with 2 jobs queued -> out fields stable, no second eng_start until handshake, then second job launches.
REQ-043 reset pulled low during WAIT -> all outputs at reset values immediately, pending=0; a new job after release gets tag 0 and completes normally.
REQ-044 eng_done arrives on exactly the TIMEOUT cycle -> engine result captured, out_err=0.
